// File: rtl/hdmi_pkg.sv
// Shared constants for the HDMI pixel-data path: pattern modes, bar colours,
// pipeline depth and counter limits.
package hdmi_pkg;

  typedef enum logic [2:0] {
    PAT_BARS  = 3'd0,
    PAT_HRAMP = 3'd1,
    PAT_VRAMP = 3'd2,
    PAT_GRID  = 3'd3,
    PAT_SOLID = 3'd4
  } pat_mode_e;

  localparam int unsigned LATENCY = 2;

  localparam logic [11:0] CNT_MAX  = 12'hFFF;
  localparam logic [2:0]  BAR_LAST = 3'd7;

  // White, yellow, cyan, green, magenta, red, blue, black as {R,G,B}.
  localparam logic [23:0] BAR_RGB [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/pattern_pos_cnt.sv
// Active-pixel position tracker: DE/VS edge detection, pixel/line counters and
// colour-bar index, all registered as pipeline stage 1.
module pattern_pos_cnt
  import hdmi_pkg::*;
(
  input  logic        I_pxl_clk,
  input  logic        I_rst_n,
  input  logic        de,
  input  logic        vs,
  input  logic [8:0]  bar_w_raw,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic [2:0]  bar,
  output logic        frame_rise,
  output logic        frame_start
);

  logic       de_q;
  logic       vs_q;
  logic [8:0] sub_q;
  logic [8:0] bar_w;

  assign bar_w      = (bar_w_raw == '0) ? 9'd1 : bar_w_raw;
  assign frame_rise = vs & ~vs_q;

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      de_q        <= 1'b0;
      vs_q        <= 1'b0;
      frame_start <= 1'b0;
      x           <= '0;
      y           <= '0;
      sub_q       <= '0;
      bar         <= '0;
    end else begin
      de_q        <= de;
      vs_q        <= vs;
      frame_start <= frame_rise;

      if (de && de_q) begin
        if (x != CNT_MAX) x <= x + 12'd1;
        if (sub_q == bar_w - 9'd1) begin
          sub_q <= '0;
          if (bar != BAR_LAST) bar <= bar + 3'd1;
        end else begin
          sub_q <= sub_q + 9'd1;
        end
      end else begin
        // First active pixel of a line and all blanking cycles start from zero.
        x     <= '0;
        sub_q <= '0;
        bar   <= '0;
      end

      // Frame start wins over a coincident DE falling edge.
      if (frame_rise)
        y <= '0;
      else if (!de && de_q && y != CNT_MAX)
        y <= y + 12'd1;
    end
  end

endmodule

// File: rtl/hdmi_pattern_gen.sv
// Test-pattern pixel stage: per-frame mode latch, RGB pattern mux and a
// fixed 2-cycle sync delay keeping DE/HS/VS aligned with the pixel data.
module hdmi_pattern_gen
  import hdmi_pkg::*;
(
  input  logic        I_pxl_clk,
  input  logic        I_rst_n,
  input  logic        I_de,
  input  logic        I_hs,
  input  logic        I_vs,
  input  logic [11:0] I_h_res,
  input  logic [11:0] I_v_res,
  input  logic [2:0]  I_mode,
  input  logic [23:0] I_solid_rgb,
  output logic        O_de,
  output logic        O_hs,
  output logic        O_vs,
  output logic [7:0]  O_data_r,
  output logic [7:0]  O_data_g,
  output logic [7:0]  O_data_b,
  output logic        O_frame_start
);

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } sync_t;

  sync_t [LATENCY-1:0] sync_pipe;
  logic [2:0]          mode_q;
  logic [11:0]         x;
  logic [11:0]         y;
  logic [2:0]          bar;
  logic                frame_rise;
  logic                frame_start_s1;
  logic [23:0]         pix;

  pattern_pos_cnt u_pos (
    .I_pxl_clk   (I_pxl_clk),
    .I_rst_n     (I_rst_n),
    .de          (I_de),
    .vs          (I_vs),
    .bar_w_raw   (I_h_res[11:3]),
    .x           (x),
    .y           (y),
    .bar         (bar),
    .frame_rise  (frame_rise),
    .frame_start (frame_start_s1)
  );

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      mode_q    <= '0;
      sync_pipe <= '0;
    end else begin
      if (frame_rise) mode_q <= I_mode;
      sync_pipe <= {sync_pipe[LATENCY-2:0], sync_t'({I_de, I_hs, I_vs})};
    end
  end

  always_comb begin
    pix = '0;
    case (mode_q)
      PAT_BARS:  pix = BAR_RGB[bar];
      PAT_HRAMP: pix = {3{x[7:0]}};
      PAT_VRAMP: pix = {3{y[7:0]}};
      PAT_GRID:
        if (x[4:0] == 5'd0 || y[4:0] == 5'd0 ||
            x == I_h_res - 12'd1 || y == I_v_res - 12'd1)
          pix = '1;
      PAT_SOLID: pix = I_solid_rgb;
      default:   pix = '0;
    endcase
  end

  // Stage 2: colour is blanked using the stage-1 DE so it matches O_de.
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      {O_data_r, O_data_g, O_data_b} <= '0;
      O_frame_start                  <= 1'b0;
    end else begin
      {O_data_r, O_data_g, O_data_b} <= sync_pipe[0].de ? pix : '0;
      O_frame_start                  <= frame_start_s1;
    end
  end

  assign O_de = sync_pipe[LATENCY-1].de;
  assign O_hs = sync_pipe[LATENCY-1].hs;
  assign O_vs = sync_pipe[LATENCY-1].vs;

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// Scoreboard bench for hdmi_pattern_gen: a timing-generator driver pushes the
// expected output of every cycle; a monitor pops and compares LATENCY cycles later.
`timescale 1ns/1ps
module tb_hdmi_pattern_gen;
  import hdmi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        de, hs, vs;
  logic [11:0] h_res, v_res;
  logic [2:0]  mode;
  logic [23:0] solid;
  logic        o_de, o_hs, o_vs, o_fs;
  logic [7:0]  o_r, o_g, o_b;

  always #5 clk = ~clk;

  hdmi_pattern_gen dut (
    .I_pxl_clk     (clk),
    .I_rst_n       (rst_n),
    .I_de          (de),
    .I_hs          (hs),
    .I_vs          (vs),
    .I_h_res       (h_res),
    .I_v_res       (v_res),
    .I_mode        (mode),
    .I_solid_rgb   (solid),
    .O_de          (o_de),
    .O_hs          (o_hs),
    .O_vs          (o_vs),
    .O_data_r      (o_r),
    .O_data_g      (o_g),
    .O_data_b      (o_b),
    .O_frame_start (o_fs)
  );

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [23:0] rgb;
  } obs_t;

  obs_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [2:0]  m_mode = 3'd0;
  logic        m_vs_prev = 1'b0;

  function automatic logic [23:0] bar_colour(int b);
    logic [7:0] r, g, bl;
    r  = ((b % 4) < 2) ? 8'hFF : 8'h00;
    g  = (b < 4)       ? 8'hFF : 8'h00;
    bl = ((b % 2) == 0) ? 8'hFF : 8'h00;
    return {r, g, bl};
  endfunction

  // Expected colour from pixel column, line-within-frame and the frame's mode.
  function automatic logic [23:0] ref_pixel(int px, int ln, logic [2:0] md);
    int xs, ys, w, b;
    logic [7:0] v8;
    xs = (px > 4095) ? 4095 : px;
    ys = (ln > 4095) ? 4095 : ln;
    case (md)
      3'd0: begin
        w = int'(h_res) / 8;
        if (w == 0) w = 1;
        b = xs / w;
        if (b > 7) b = 7;
        return bar_colour(b);
      end
      3'd1: begin v8 = 8'(xs % 256); return {v8, v8, v8}; end
      3'd2: begin v8 = 8'(ys % 256); return {v8, v8, v8}; end
      3'd3: return (xs % 32 == 0 || ys % 32 == 0 ||
                    xs == int'(h_res) - 1 || ys == int'(v_res) - 1) ? 24'hFFFFFF : 24'h0;
      3'd4: return solid;
      default: return 24'h0;
    endcase
  endfunction

  task automatic step(input bit r, input bit d, input bit h, input bit v,
                      input int px, input int ln);
    obs_t e;
    @(posedge clk);
    #1;
    if (!r && rst_n) foreach (exp_q[i]) exp_q[i] = '0;
    rst_n = r; de = d; hs = h; vs = v;
    e = '0;
    if (r) begin
      if (v && !m_vs_prev) m_mode = mode;
      e.de = d; e.hs = h; e.vs = v;
      e.fs = v && !m_vs_prev;
      if (d) e.rgb = ref_pixel(px, ln, m_mode);
      m_vs_prev = v;
    end else begin
      m_mode    = 3'd0;
      m_vs_prev = 1'b0;
    end
    exp_q.push_back(e);
  endtask

  task automatic line(input int ln, input int act, input int hb, input int rp);
    for (int p = 0; p < act; p++)
      step(!(rp >= 0 && p >= rp), 1'b1, 1'b0, 1'b0, p, ln);
    for (int i = 0; i < hb; i++)
      step(!(rp >= 0 && i < 2), 1'b0, (i >= 1 && i < hb - 1), 1'b0, 0, ln);
  endtask

  task automatic frame(input int h, input int v, input int nl, input int act,
                       input int hb, input logic [2:0] md, input int lead,
                       input bit tight, input int chg_line, input logic [2:0] chg_md,
                       input int rst_line, input int rst_px, input logic [23:0] sol);
    mode = md;
    for (int i = 0; i < lead + 14; i++) begin
      if (i == 3) begin
        h_res = 12'(h); v_res = 12'(v); solid = sol;
      end
      step(1'b1, 1'b0, 1'b0, (i >= lead && i < lead + 8), 0, 0);
    end
    for (int l = 0; l < nl; l++) begin
      if (l == chg_line) mode = chg_md;
      line(l, act, (tight && l == nl - 1) ? 0 : hb, (l == rst_line) ? rst_px : -1);
    end
  endtask

  initial begin : monitor
    obs_t e, got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > int'(LATENCY)) begin
        e   = exp_q.pop_front();
        got = {o_de, o_hs, o_vs, o_fs, o_r, o_g, o_b};
        checks++;
        if (got !== e) begin
          errors++;
          if (errors <= 20)
            $display("FAIL pixel_out t=%0t got de=%b hs=%b vs=%b fs=%b rgb=%h expected de=%b hs=%b vs=%b fs=%b rgb=%h",
                     $time, got.de, got.hs, got.vs, got.fs, got.rgb,
                     e.de, e.hs, e.vs, e.fs, e.rgb);
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: time limit reached got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin : driver
    int h, v, nl, act, hb, rl, rp;
    rst_n = 1'b0; de = 1'b0; hs = 1'b0; vs = 1'b0;
    h_res = 12'd800; v_res = 12'd600; mode = 3'd1; solid = 24'h0;

    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    line(0, 800, 10, -1);                                               // mode 0 before any VS rise
    frame(800, 600, 2, 800, 16, 3'd0, 4, 0, -1, 3'd0, -1, 0, 24'h0);    // bars
    frame(800, 600, 2, 800, 16, 3'd1, 4, 0, -1, 3'd0, -1, 0, 24'h0);    // h ramp
    frame(800, 600, 1, 4100, 16, 3'd1, 4, 0, -1, 3'd0, -1, 0, 24'h0);   // x saturation
    frame(64, 300, 300, 16, 4, 3'd2, 4, 1, -1, 3'd0, -1, 0, 24'h0);     // v ramp, tight end
    frame(800, 600, 600, 40, 6, 3'd3, 0, 0, -1, 3'd0, -1, 0, 24'h0);    // grid, VS rise on DE fall
    frame(800, 600, 12, 800, 10, 3'd3, 4, 0, -1, 3'd0, -1, 0, 24'h0);   // grid right edge
    frame(800, 600, 3, 800, 10, 3'd0, 4, 0, 1, 3'd4, -1, 0, 24'h123456); // mid-frame mode change
    frame(800, 600, 2, 800, 10, 3'd4, 4, 0, -1, 3'd0, -1, 0, 24'h123456); // solid
    frame(4, 3, 3, 10, 4, 3'd0, 4, 0, -1, 3'd0, -1, 0, 24'h0);          // narrow bars
    frame(800, 600, 3, 800, 10, 3'd2, 4, 0, -1, 3'd0, 1, 350, 24'h0);   // reset mid-line
    frame(800, 600, 2, 800, 10, 3'd2, 4, 0, -1, 3'd0, -1, 0, 24'h0);

    for (int k = 0; k < 6; k++) begin
      h   = int'($urandom_range(4, 96));
      v   = int'($urandom_range(1, 20));
      nl  = int'($urandom_range(2, 12));
      act = h + (($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20)) : 0);
      hb  = int'($urandom_range(3, 12));
      rl  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, nl - 1)) : -1;
      rp  = int'($urandom_range(0, act - 1));
      frame(h, v, nl, act, hb, 3'($urandom_range(0, 7)), 4, 0, -1, 3'd0, rl, rp, 24'($urandom()));
    end

    repeat (6) step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
